// File: rtl/control_riego.sv
// Irrigation controller: synchronises and debounces the dry-soil comparator, runs a bounded
// watering cycle plus cooldown, and latches a fault after repeated watering timeouts.
module control_riego #(
    parameter int unsigned DEB_CYCLES   = 1_000_000,
    parameter int unsigned WATER_CYCLES = 500_000_000,
    parameter int unsigned MIN_CYCLES   = 50_000_000,
    parameter int unsigned COOL_CYCLES  = 1_500_000_000,
    parameter int unsigned MAX_TIMEOUTS = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       seco_i,
    output logic       regar_o,
    output logic [1:0] estado_o,
    output logic [7:0] riegos_o,
    output logic       falla_o
);

    localparam logic [19:0] DebLast   = 20'(DEB_CYCLES - 1);
    localparam logic [30:0] WaterLast = 31'(WATER_CYCLES - 1);
    localparam logic [30:0] MinLast   = 31'(MIN_CYCLES - 1);
    localparam logic [30:0] CoolLast  = 31'(COOL_CYCLES - 1);
    localparam logic [1:0]  MaxTo     = 2'(MAX_TIMEOUTS);

    typedef enum logic [1:0] {StIdle = 2'd0, StWater = 2'd1, StCool = 2'd2, StFault = 2'd3} state_e;

    state_e      state_q, state_d;
    logic        seco_meta_q, seco_s_q;
    logic        seco_db_q, seco_db_d;
    logic [19:0] deb_cnt_q, deb_cnt_d;
    logic [30:0] t_q, t_d;
    logic [7:0]  riegos_q, riegos_d;
    logic [1:0]  to_q, to_d;
    logic [1:0]  to_inc;
    logic        falla_q, falla_d;

    always_comb begin
        seco_db_d = seco_db_q;
        deb_cnt_d = 20'd0;
        if (seco_s_q != seco_db_q) begin
            if (deb_cnt_q == DebLast) begin
                seco_db_d = seco_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 20'd1;
            end
        end
    end

    // The FSM decides on the pre-flip seco_db_q, so a same-cycle debounce flip is seen next cycle.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        riegos_d = riegos_q;
        to_d     = to_q;
        falla_d  = falla_q;
        to_inc   = to_q + 2'd1;
        case (state_q)
            StIdle: begin
                if (enable_i && seco_db_q) begin
                    state_d = StWater;
                    t_d     = 31'd0;
                    if (riegos_q != 8'hFF) begin
                        riegos_d = riegos_q + 8'd1;
                    end
                end
            end
            StWater: begin
                t_d = t_q + 31'd1;
                if (!enable_i) begin
                    state_d = StIdle;
                    t_d     = 31'd0;
                end else if (t_q == WaterLast) begin
                    to_d = to_inc;
                    t_d  = 31'd0;
                    if (to_inc == MaxTo) begin
                        state_d = StFault;
                        falla_d = 1'b1;
                    end else begin
                        state_d = StCool;
                    end
                end else if (!seco_db_q && (t_q >= MinLast)) begin
                    state_d = StCool;
                    t_d     = 31'd0;
                    to_d    = 2'd0;
                end
            end
            StCool: begin
                t_d = t_q + 31'd1;
                if (t_q == CoolLast) begin
                    state_d = StIdle;
                    t_d     = 31'd0;
                end
            end
            StFault: begin
                if (!enable_i) begin
                    state_d = StIdle;
                    falla_d = 1'b0;
                    to_d    = 2'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seco_meta_q <= 1'b0;
            seco_s_q    <= 1'b0;
            seco_db_q   <= 1'b0;
            deb_cnt_q   <= 20'd0;
            state_q     <= StIdle;
            t_q         <= 31'd0;
            riegos_q    <= 8'd0;
            to_q        <= 2'd0;
            falla_q     <= 1'b0;
        end else begin
            seco_meta_q <= seco_i;
            seco_s_q    <= seco_meta_q;
            seco_db_q   <= seco_db_d;
            deb_cnt_q   <= deb_cnt_d;
            state_q     <= state_d;
            t_q         <= t_d;
            riegos_q    <= riegos_d;
            to_q        <= to_d;
            falla_q     <= falla_d;
        end
    end

    assign regar_o  = (state_q == StWater);
    assign estado_o = state_q;
    assign riegos_o = riegos_q;
    assign falla_o  = falla_q;

endmodule

// File: tb/tb_control_riego.sv
// Directed bench for control_riego: a behavioural model is compared against the DUT every cycle,
// with hand-computed literal checks at the milestones of each scenario.
module tb_control_riego;

    localparam int DEB   = 4;
    localparam int WATER = 20;
    localparam int MIN   = 5;
    localparam int COOL  = 10;
    localparam int MAXT  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       seco;
    logic       regar;
    logic [1:0] estado;
    logic [7:0] riegos;
    logic       falla;

    int errors = 0;
    int checks = 0;

    control_riego #(
        .DEB_CYCLES  (DEB),
        .WATER_CYCLES(WATER),
        .MIN_CYCLES  (MIN),
        .COOL_CYCLES (COOL),
        .MAX_TIMEOUTS(MAXT)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .enable_i(enable),
        .seco_i  (seco),
        .regar_o (regar),
        .estado_o(estado),
        .riegos_o(riegos),
        .falla_o (falla)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 watering, 2 cooling, 3 fault; el = cycles already spent in mode.
    typedef struct {
        int s1;
        int s2;
        int db;
        int run;
        int mode;
        int el;
        int riegos;
        int tos;
        int falla;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t model_next(mdl_t c, bit en, bit sc);
        mdl_t n = c;
        // db flips on the DEB-th consecutive sample that disagrees with it
        if (c.s2 != c.db) begin
            n.run = c.run + 1;
            if (n.run == DEB) begin
                n.db  = c.s2;
                n.run = 0;
            end
        end else begin
            n.run = 0;
        end
        n.s2 = c.s1;
        n.s1 = int'(sc);
        case (c.mode)
            0: if (en && c.db == 1) begin
                n.mode   = 1;
                n.el     = 0;
                n.riegos = (c.riegos < 255) ? c.riegos + 1 : 255;
            end
            1: begin
                if (!en) begin
                    n.mode = 0;
                    n.el   = 0;
                end else if (c.el + 1 == WATER) begin
                    n.tos = c.tos + 1;
                    n.el  = 0;
                    if (n.tos == MAXT) begin
                        n.mode  = 3;
                        n.falla = 1;
                    end else begin
                        n.mode = 2;
                    end
                end else if (c.db == 0 && c.el + 1 >= MIN) begin
                    n.mode = 2;
                    n.el   = 0;
                    n.tos  = 0;
                end else begin
                    n.el = c.el + 1;
                end
            end
            2: begin
                if (c.el + 1 == COOL) begin
                    n.mode = 0;
                    n.el   = 0;
                end else begin
                    n.el = c.el + 1;
                end
            end
            default: if (!en) begin
                n.mode  = 0;
                n.falla = 0;
                n.tos   = 0;
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{default: 0};
        end else begin
            m <= model_next(m, enable, seco);
        end
    end

    task automatic lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Advance one cycle and compare all outputs with the model on the falling edge.
    task automatic tick();
        int exp_regar;
        @(negedge clk);
        exp_regar = (m.mode == 1) ? 1 : 0;
        checks++;
        if (int'(regar) != exp_regar || int'(estado) != m.mode || int'(riegos) != m.riegos ||
            int'(falla) != m.falla) begin
            errors++;
            $display("FAIL cycle @%0t: got regar=%0d estado=%0d riegos=%0d falla=%0d, want %0d %0d %0d %0d",
                     $time, regar, estado, riegos, falla, exp_regar, m.mode, m.riegos, m.falla);
        end
    endtask

    task automatic wait_regar(input bit lvl, input int max_cyc, input string name, output int n);
        n = 0;
        while (regar != lvl && n < max_cyc) begin
            tick();
            n++;
        end
        if (regar != lvl) begin
            checks++;
            errors++;
            $display("FAIL %s: regar=%0d after %0d cycles, want %0d", name, regar, n, lvl);
        end
    endtask

    initial begin
        int n;
        int hi;
        rst_n  = 1'b0;
        enable = 1'b0;
        seco   = 1'b0;
        #12;
        lit("reset_regar", int'(regar), 0);
        lit("reset_estado", int'(estado), 0);
        lit("reset_riegos", int'(riegos), 0);
        lit("reset_falla", int'(falla), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: wet soil, enabled: nothing happens
        enable = 1'b1;
        repeat (50) tick();
        lit("t1_riegos", int'(riegos), 0);
        lit("t1_regar", int'(regar), 0);

        // 2: 3-cycle glitch is filtered
        seco = 1'b1;
        repeat (3) tick();
        seco = 1'b0;
        repeat (12) tick();
        lit("t2_estado", int'(estado), 0);
        lit("t2_riegos", int'(riegos), 0);

        // 3: permanently dry -> three timeouts -> fault
        seco = 1'b1;
        wait_regar(1'b1, 20, "t3_rise", n);
        lit("t3_rise_edges", n, DEB + 3);  // rise at edge k+DEB+2, k = first edge after drive
        hi = 1;
        while (regar && hi < 40) begin
            tick();
            if (regar) hi++;
        end
        lit("t3_high_time", hi, WATER);
        n = 0;
        while (estado != 2'd3 && n < 200) begin
            tick();
            n++;
        end
        lit("t3_estado_fault", int'(estado), 3);
        lit("t3_riegos", int'(riegos), 3);
        lit("t3_falla", int'(falla), 1);
        lit("t3_regar_fault", int'(regar), 0);
        enable = 1'b0;
        seco   = 1'b0;
        tick();
        lit("t3_exit_estado", int'(estado), 0);
        lit("t3_exit_falla", int'(falla), 0);
        repeat (10) tick();
        enable = 1'b1;
        repeat (5) tick();

        // 4: wet reading two cycles into watering ends it early
        seco = 1'b1;
        wait_regar(1'b1, 20, "t4_rise", n);
        tick();
        seco = 1'b0;
        hi = 1;
        while (regar && hi < 40) begin
            hi++;
            tick();
        end
        lit("t4_high_time", hi, 8);
        lit("t4_model_timeouts", m.tos, 0);
        lit("t4_riegos", int'(riegos), 4);
        repeat (20) tick();

        // 5: enable dropped at t=8
        seco = 1'b1;
        wait_regar(1'b1, 20, "t5_rise", n);
        repeat (8) tick();
        enable = 1'b0;
        tick();
        lit("t5_regar", int'(regar), 0);
        lit("t5_estado", int'(estado), 0);
        lit("t5_riegos", int'(riegos), 5);
        seco = 1'b0;
        repeat (10) tick();
        enable = 1'b1;
        repeat (3) tick();

        // 6: asynchronous reset mid-watering
        seco = 1'b1;
        wait_regar(1'b1, 20, "t6_rise", n);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        lit("t6_regar", int'(regar), 0);
        lit("t6_estado", int'(estado), 0);
        lit("t6_riegos", int'(riegos), 0);
        lit("t6_falla", int'(falla), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (15) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
